// File: rtl/result_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : result_reader_if
// Brief    : Valid/ready beat stream from the result drain to the host/DMA side.
//            out_last is present only when RESULT_READER_LAST_EN is defined.
// Revision : 1.0
// ============================================================================
interface result_reader_if #(
    parameter int PARTIAL_SUM_BW = 24,
    parameter int LANES          = 8
);
    logic [PARTIAL_SUM_BW*LANES-1:0] out_data;
    logic                            out_valid;
    logic                            out_ready;
`ifdef RESULT_READER_LAST_EN
    logic                            out_last;

    modport master (output out_data, output out_valid, output out_last, input  out_ready);
    modport slave  (input  out_data, input  out_valid, input  out_last, output out_ready);
`else
    modport master (output out_data, output out_valid, input  out_ready);
    modport slave  (input  out_data, input  out_valid, output out_ready);
`endif
endinterface
`default_nettype wire

// File: rtl/result_reader.sv
`default_nettype none
// ============================================================================
// Module   : result_reader
// Brief    : Drains NUM_ROWS rows of the result SRAM from a programmable base
//            and serializes each row into LANES-wide valid/ready beats.
//            Optional: RESULT_READER_LAST_EN adds out_last on each row's final beat.
// Revision : 1.0
// ============================================================================
module result_reader #(
    parameter int ADDRESSSIZE    = 10,
    parameter int MATRIX_SIZE    = 64,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int LANES          = 8,
    parameter int NUM_ROWS       = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [ADDRESSSIZE-1:0]              base_addr,
    output logic [ADDRESSSIZE-1:0]              rd_address,
    output logic                                rd_active,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] rd_data,
    result_reader_if.master                     bus,
    output logic                                busy,
    output logic                                done
);
    localparam int c_BEATS     = MATRIX_SIZE / LANES;
    localparam int c_BEAT_W    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int c_BEAT_BITS = PARTIAL_SUM_BW * LANES;
    localparam int c_ROW_BITS  = PARTIAL_SUM_BW * MATRIX_SIZE;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);
    localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_CAPT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDRESSSIZE-1:0]  r_base;
    logic [ADDRESSSIZE-1:0]  r_rd_address;
    logic [c_ROW_W-1:0]      r_row;
    logic [c_BEAT_W-1:0]     r_beat;
    logic [c_ROW_BITS-1:0]   r_row_reg;
    logic [c_ROW_W-1:0]      w_next_row;
    logic                    w_busy;
    logic                    w_valid;
    logic                    w_done;
    logic                    w_xfer;
    logic                    w_last_beat;

    assign w_next_row  = r_row + 1'b1;
    assign w_last_beat = (r_beat == c_LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_valid      = 1'b0;
        w_done       = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                w_busy       = 1'b1;
                w_next_state = S_CAPT;
            end
            S_CAPT: begin
                w_busy       = 1'b1;
                w_next_state = S_SEND;
            end
            S_SEND: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
                w_xfer  = bus.out_ready;
                if (bus.out_ready && w_last_beat) begin
                    w_next_state = (r_row == c_LAST_ROW) ? S_DONE : S_ADDR;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // The address is loaded on entry to ADDR so the SRAM samples it at the
    // end of ADDR and its data is ready to capture during CAPT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base       <= '0;
            r_rd_address <= '0;
            r_row        <= '0;
            r_beat       <= '0;
            r_row_reg    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base       <= base_addr;
                        r_rd_address <= base_addr;
                        r_row        <= '0;
                    end
                end
                S_CAPT: begin
                    r_row_reg <= rd_data;
                    r_beat    <= '0;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (!w_last_beat) begin
                            r_beat <= r_beat + 1'b1;
                        end else if (r_row != c_LAST_ROW) begin
                            r_row        <= w_next_row;
                            r_rd_address <= r_base + ADDRESSSIZE'(w_next_row);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_address    = r_rd_address;
    assign rd_active     = w_busy;
    assign busy          = w_busy;
    assign done          = w_done;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = r_row_reg[int'(r_beat) * c_BEAT_BITS +: c_BEAT_BITS];

`ifdef RESULT_READER_LAST_EN
    assign bus.out_last  = w_valid && w_last_beat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_result_reader
// Brief    : Self-checking bench for result_reader against a queue-based beat model.
// Revision : 1.0
// ============================================================================
module tb_result_reader;
    localparam int ADDRESSSIZE    = 10;
    localparam int MATRIX_SIZE    = 64;
    localparam int PARTIAL_SUM_BW = 24;
    localparam int LANES          = 8;
    localparam int NUM_ROWS       = 64;
    localparam int BEATS          = MATRIX_SIZE / LANES;
    localparam int BEAT_BITS      = PARTIAL_SUM_BW * LANES;
    localparam int ROW_BITS       = PARTIAL_SUM_BW * MATRIX_SIZE;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [ADDRESSSIZE-1:0] base_addr = '0;
    logic [ADDRESSSIZE-1:0] rd_address;
    logic                   rd_active;
    logic [ROW_BITS-1:0]    rd_data = '0;
    logic                   busy;
    logic                   done;

    result_reader_if #(.PARTIAL_SUM_BW(PARTIAL_SUM_BW), .LANES(LANES)) bus ();

    result_reader #(
        .ADDRESSSIZE   (ADDRESSSIZE),
        .MATRIX_SIZE   (MATRIX_SIZE),
        .PARTIAL_SUM_BW(PARTIAL_SUM_BW),
        .LANES         (LANES),
        .NUM_ROWS      (NUM_ROWS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .rd_address(rd_address),
        .rd_active (rd_active),
        .rd_data   (rd_data),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [BEAT_BITS-1:0] act, input logic [BEAT_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM contents: address a, lane k holds a*64+k.
    function automatic logic [ROW_BITS-1:0] row_val(input logic [ADDRESSSIZE-1:0] a);
        logic [ROW_BITS-1:0] v;
        v = '0;
        for (int k = 0; k < MATRIX_SIZE; k++) v[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = 24'(int'(a) * 64 + k);
        return v;
    endfunction

    function automatic logic [BEAT_BITS-1:0] beat_val(input int a, input int b);
        logic [BEAT_BITS-1:0] v;
        v = '0;
        for (int j = 0; j < LANES; j++) v[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = 24'(a * 64 + b * LANES + j);
        return v;
    endfunction

    always @(posedge clk) rd_data <= row_val(rd_address);

    // Sink readiness: always 1, or the 1,0,0,1 pattern in backpressure mode.
    logic       bp_mode = 1'b0;
    logic [3:0] pat     = 4'b1001;
    int         rcyc    = 0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp_mode ? pat[rcyc % 4] : 1'b1;
            rcyc++;
        end
    end

    // Behavioural model: a drain is the ordered list of all beats of all rows.
    logic [BEAT_BITS-1:0] exp_q[$];
    logic                 draining = 1'b0;
    logic                 done_exp = 1'b0;
    logic                 can_start;
    int                   pops = 0;
    logic [BEAT_BITS-1:0] first_beat;
    logic [BEAT_BITS-1:0] last_beat;
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                draining = 1'b0;
                done_exp = 1'b0;
                pops     = 0;
            end else begin
                can_start = !draining && !done_exp;
                done_exp  = 1'b0;
                if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                    if (pops == 0) first_beat = bus.out_data;
                    last_beat = bus.out_data;
                    void'(exp_q.pop_front());
                    pops++;
                    if (exp_q.size() == 0) begin
                        draining = 1'b0;
                        done_exp = 1'b1;
                    end
                end
                if (start && can_start) begin
                    for (int r = 0; r < NUM_ROWS; r++)
                        for (int b = 0; b < BEATS; b++)
                            exp_q.push_back(beat_val((int'(base_addr) + r) % (1 << ADDRESSSIZE), b));
                    draining = 1'b1;
                    pops     = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    logic                 chk_en     = 1'b0;
    logic                 log_en     = 1'b0;
    logic                 prev_stall = 1'b0;
    logic [BEAT_BITS-1:0] prev_data  = '0;
    logic [ADDRESSSIZE-1:0] addr_log[$];
    int                   done_count = 0;
    int                   last_count = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (done) done_count++;
                chk("busy", busy, draining);
                chk("rd_active", rd_active, draining);
                chk("done", done, done_exp);
                if (!draining) chk("valid_idle", bus.out_valid, 1'b0);
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) chk("beat_extra", bus.out_valid, 1'b0);
                    else chk("out_data", bus.out_data, exp_q[0]);
                end
                if (prev_stall) begin
                    chk("valid_hold", bus.out_valid, 1'b1);
                    chk("data_hold", bus.out_data, prev_data);
                end
`ifdef RESULT_READER_LAST_EN
                chk("out_last", bus.out_last, bus.out_valid && (pops % BEATS == BEATS - 1));
                if (bus.out_valid && bus.out_last) last_count++;
`endif
                if (log_en && rd_active && (addr_log.size() == 0 || rd_address != addr_log[$]))
                    addr_log.push_back(rd_address);
                prev_stall = bus.out_valid && !bus.out_ready && !rst;
                prev_data  = bus.out_data;
            end
        end
    end

    task automatic run_drain(input logic [ADDRESSSIZE-1:0] b, output int first_v, output int done_n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        @(negedge clk);
        @(posedge clk);
        #1;
        start   = 1'b0;
        first_v = -1;
        done_n  = -1;
        for (int n = 1; n < 3000 && done_n < 0; n++) begin
            @(negedge clk);
            if (bus.out_valid && first_v < 0) first_v = n;
            if (done) done_n = n;
        end
        if (done_n < 0) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (pops != target && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pops != target) chk("pops_timeout", BEAT_BITS'(pops), BEAT_BITS'(target));
    endtask

    int                   fv, dn, dc;
    logic [BEAT_BITS-1:0] lit;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_address", rd_address, '0);
        chk("rst_rd_active", rd_active, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk_en = 1'b1;

        // Basic drain from base 0
        last_count = 0;
        run_drain(10'd0, fv, dn);
        chk("first_valid_latency", BEAT_BITS'(fv), BEAT_BITS'(3));
        chk("done_cycle", BEAT_BITS'(dn), BEAT_BITS'(641));
        chk("beat_count", BEAT_BITS'(pops), BEAT_BITS'(512));
        for (int j = 0; j < LANES; j++) lit[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = 24'(j);
        chk("first_beat_lit", first_beat, lit);
        for (int j = 0; j < LANES; j++) lit[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = 24'(4088 + j);
        chk("last_beat_lit", last_beat, lit);
`ifdef RESULT_READER_LAST_EN
        chk("last_pulses", BEAT_BITS'(last_count), BEAT_BITS'(64));
`endif

        // Backpressure 1,0,0,1
        bp_mode = 1'b1;
        run_drain(10'd0, fv, dn);
        chk("bp_beat_count", BEAT_BITS'(pops), BEAT_BITS'(512));
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);

        // Address wrap from 1000
        addr_log.delete();
        log_en = 1'b1;
        run_drain(10'd1000, fv, dn);
        log_en = 1'b0;
        chk("wrap_log_size", BEAT_BITS'(addr_log.size()), BEAT_BITS'(64));
        if (addr_log.size() == 64) begin
            for (int i = 0; i < 64; i++) chk("wrap_addr_seq", addr_log[i], BEAT_BITS'((1000 + i) % 1024));
            chk("wrap_addr_1023", addr_log[23], BEAT_BITS'(1023));
            chk("wrap_addr_0", addr_log[24], BEAT_BITS'(0));
            chk("wrap_addr_39", addr_log[63], BEAT_BITS'(39));
        end

        // Start while busy at beat 100
        dc = done_count;
        @(posedge clk);
        #1 start = 1'b1; base_addr = 10'd0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_pops(100);
        start = 1'b1; base_addr = 10'd5;
        @(posedge clk);
        #1 start = 1'b0; base_addr = 10'd0;
        begin
            int n;
            n = 0;
            while (done_count == dc && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (20) @(negedge clk);
        chk("busy_start_done_once", BEAT_BITS'(done_count - dc), BEAT_BITS'(1));
        chk("busy_start_beats", BEAT_BITS'(pops), BEAT_BITS'(512));

        // Reset during row 3, beat 4
        @(posedge clk);
        #1 start = 1'b1; base_addr = 10'd0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_pops(28);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rd_active", rd_active, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_out_data", bus.out_data, '0);
        chk("mid_rst_rd_address", rd_address, '0);
        dc = done_count;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_done", BEAT_BITS'(done_count), BEAT_BITS'(dc));
        run_drain(10'd300, fv, dn);
        chk("post_rst_done_cycle", BEAT_BITS'(dn), BEAT_BITS'(641));
        chk("post_rst_beats", BEAT_BITS'(pops), BEAT_BITS'(512));

        repeat (5) @(negedge clk);
        chk("total_done_pulses", BEAT_BITS'(done_count), BEAT_BITS'(5));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/result_reader.md
Name: result_reader

Overview:
Drains the result SRAM after a systolic matrix pass. This is the read-side counterpart of the result write path, which writes rows 0..63 from the 7-bit result counter. On a start pulse the block reads NUM_ROWS consecutive rows, starting at a programmable base address. Each row of MATRIX_SIZE partial sums is serialized into fixed-width beats and sent out on a valid/ready stream toward the host or DMA side. The top level muxes the result SRAM address port to this block while rd_active is high.

Parameters:
ADDRESSSIZE, 10, result SRAM address width
MATRIX_SIZE, 64, partial sums per SRAM row
PARTIAL_SUM_BW, 24, bits per partial sum (signed)
LANES, 8, partial sums per output beat; MATRIX_SIZE must be a multiple of LANES
NUM_ROWS, 64, rows drained per start

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a drain; ignored unless idle
base_addr  in  ADDRESSSIZE  first row address; sampled with start
rd_address  out  ADDRESSSIZE  result SRAM address (registered)
rd_active  out  1  high while the block owns the SRAM port
rd_data  in  PARTIAL_SUM_BW*MATRIX_SIZE  SRAM data_out; valid 1 cycle after the address edge
out_data  out  PARTIAL_SUM_BW*LANES  current beat
out_valid  out  1  beat valid
out_ready  in  1  sink accepts the beat
busy  out  1  drain in progress
done  out  1  one-cycle pulse when the last beat is accepted

Behaviour:
- BEATS = MATRIX_SIZE/LANES (default 8). Row counter and beat counter are sized by $clog2.
- Reset values: rd_address=0, rd_active=0, out_data=0, out_valid=0, busy=0, done=0, state=IDLE.
- IDLE:
  - start=1 latches base_addr into the address register and clears the row counter.
  - Next state ADDR. busy and rd_active go high the cycle after start.
- ADDR:
  - rd_address = base_addr + row, modulo 2^ADDRESSSIZE (wraps silently).
  - Next state CAPT.
- CAPT:
  - rd_data is valid. Latch it into the row register; beat=0.
  - Next state SEND.
- SEND:
  - out_valid=1. out_data = row_reg[(beat+1)*LANES*PARTIAL_SUM_BW-1 : beat*LANES*PARTIAL_SUM_BW]. Beat 0 (lane 0, LSBs) is sent first.
  - A transfer occurs on out_valid & out_ready at the clock edge.
  - out_data is held stable while out_valid=1 and out_ready=0. out_valid never drops without a transfer.
  - Transfer with beat<BEATS-1: beat+1.
  - Transfer on beat BEATS-1 with row<NUM_ROWS-1: row+1, out_valid drops, next state ADDR.
  - Transfer on beat BEATS-1 with row=NUM_ROWS-1: next state DONE.
- DONE:
  - done=1 for exactly one cycle. busy, rd_active and out_valid are 0.
  - Next state IDLE.
- Latency: first out_valid is high 3 cycles after the start cycle (ADDR, CAPT, then SEND).
- Per-row overhead is 2 idle cycles. With out_ready tied high, a drain takes NUM_ROWS*(BEATS+2)+1 cycles from start to done.
- start while busy or in DONE: ignored, with no effect on the counters.
- rst mid-drain: returns to IDLE next edge, all outputs at reset values, the partial row is discarded, done is not pulsed.
- out_ready high in IDLE/ADDR/CAPT: no effect.
- rd_address holds its last value when idle.
- Data is passed through bit-exact; no sign extension or arithmetic is applied.

Optional Feature:
Macro RESULT_READER_LAST_EN.
- Defined: adds output port out_last (1 bit, reset 0). out_last is high with out_valid on the final beat of each row, i.e. beat=BEATS-1, and otherwise 0.
- Not defined: the port does not exist and behaviour is otherwise identical.

Test Plan:
- Basic drain: SRAM model with row r lane k = r*64+k, out_ready=1, start with base_addr=0.
  - 512 beats total; beat 0 lanes = 0..7; last beat lanes = 4088..4095.
  - done pulses exactly once, at cycle 64*10+1 after start.
- Backpressure: out_ready toggling with the pattern 1,0,0,1.
  - out_data is stable across every stalled cycle and no beat is lost or duplicated; checked by a scoreboard over all 512 beats.
- Address wrap: base_addr=1000 with ADDRESSSIZE=10.
  - rd_address sequence is 1000..1023 then 0..39; rd_active is high throughout the drain.
- Start while busy: a second start at beat 100 with base_addr=5.
  - Ignored: the stream continues from the original base, and only one done pulse occurs.
- Reset mid-row: assert rst during row 3, beat 4.
  - Next cycle out_valid=0, busy=0, rd_active=0, and done never pulses.
  - A subsequent start drains cleanly from the new base.
- RESULT_READER_LAST_EN defined: out_last is high exactly on beats 7, 15, ..., 511 (64 pulses total).
